// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier.
// The counter width is derived from WIDTH so the step count WIDTH itself fits.
`timescale 1ns/1ps
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int COUNT_W       = $clog2(DEFAULT_WIDTH + 1);

    function automatic int countWidth(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: conditional add/subtract of M into ACC,
// followed by an arithmetic right shift of {ACC, Q, q_1}.
`timescale 1ns/1ps
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   i_acc,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_q1,
    input  logic [WIDTH:0]   i_m,
    output logic [WIDTH:0]   o_acc,
    output logic [WIDTH-1:0] o_q,
    output logic             o_q1
);

    logic [WIDTH:0] w_sum;

    // ACC is one bit wider than the operands so that M = -2^(WIDTH-1) never overflows.
    always_comb begin
        w_sum = i_acc;
        case ({i_q[0], i_q1})
            2'b01:   w_sum = i_acc + i_m;
            2'b10:   w_sum = i_acc - i_m;
            default: w_sum = i_acc;
        endcase
    end

    assign {o_acc, o_q, o_q1} = {w_sum[WIDTH], w_sum, i_q};

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed multiplier, one Booth step per clock, with a level-style
// en/ready handshake: the product is held in DONE until en is dropped.
`timescale 1ns/1ps
module booth_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   Output,
    output logic                 ready
);

    localparam int CW = countWidth(WIDTH);

    state_t           r_state;
    logic [WIDTH:0]   r_m;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic             r_q1;
    logic [CW-1:0]    r_count;

    logic [WIDTH:0]   w_acc;
    logic [WIDTH-1:0] w_q;
    logic             w_q1;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_acc (r_acc),
        .i_q   (r_q),
        .i_q1  (r_q1),
        .i_m   (r_m),
        .o_acc (w_acc),
        .o_q   (w_q),
        .o_q1  (w_q1)
    );

    // Operands are captured only on the start edge; en is ignored while running,
    // and DONE needs en low for an edge before another start is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_m     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_q1    <= 1'b0;
            r_count <= '0;
            Output  <= '0;
            ready   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    ready <= 1'b0;
                    if (en) begin
                        r_m     <= {A[WIDTH-1], A};
                        r_acc   <= '0;
                        r_q     <= B;
                        r_q1    <= 1'b0;
                        r_count <= CW'(WIDTH);
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc   <= w_acc;
                    r_q     <= w_q;
                    r_q1    <= w_q1;
                    r_count <= r_count - 1'b1;
                    if (r_count == CW'(1)) begin
                        Output  <= {w_acc[WIDTH-1:0], w_q};
                        ready   <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (!en) begin
                        ready   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    ready   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed bench for booth_multiplier: a reference product is queued at every
// start and popped when ready rises, with latency and hold behaviour checked.
`timescale 1ns/1ps
module tb_booth_multiplier;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] Output;
    logic        ready;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] expQ[$];
    logic [15:0] lastOut = 16'h0000;

    booth_multiplier #(
        .WIDTH (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .A      (A),
        .B      (B),
        .Output (Output),
        .ready  (ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] p;
        A  = a;
        B  = b;
        en = 1'b1;
        p  = $signed(a) * $signed(b);
        expQ.push_back(p);
    endtask

    // Runs one operation from a negedge: start edge, eight RUN edges, then the
    // product must appear with ready. Optionally disturbs inputs mid-run.
    task automatic runOp(input logic [7:0] a, input logic [7:0] b, input bit perturb);
        logic [15:0] exp;
        applyStimulus(a, b);
        @(posedge clk);
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            checkOutput($sformatf("readyLow_e%0d", e), {15'b0, ready}, 16'h0000);
            checkOutput($sformatf("outHeld_e%0d", e), Output, lastOut);
            if (perturb && e == 3) begin
                A  = ~a;
                B  = b + 8'd37;
                en = 1'b0;
            end
            @(posedge clk);
        end
        @(negedge clk);
        checkOutput("readyHigh", {15'b0, ready}, 16'h0001);
        if (expQ.size() == 0) begin
            checkOutput("scoreboardEmpty", 16'h0001, 16'h0000);
        end else begin
            exp = expQ.pop_front();
            checkOutput($sformatf("product_%0d_x_%0d", $signed(a), $signed(b)), Output, exp);
            lastOut = exp;
        end
    endtask

    task automatic releaseEn();
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("readyDrop", {15'b0, ready}, 16'h0000);
        checkOutput("outKept", Output, lastOut);
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        A     = 8'h00;
        B     = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("resetOut", Output, 16'h0000);
        checkOutput("resetReady", {15'b0, ready}, 16'h0000);
        reset = 1'b0;

        runOp(8'd129, 8'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("holdReady", {15'b0, ready}, 16'h0001);
            checkOutput("holdOut", Output, lastOut);
        end
        releaseEn();

        runOp(8'd7, 8'd3, 1'b0);
        releaseEn();
        runOp(8'h80, 8'd127, 1'b0);
        releaseEn();
        runOp(8'h80, 8'h80, 1'b0);
        releaseEn();
        runOp(8'h00, 8'h55, 1'b0);
        releaseEn();
        runOp(8'hFF, 8'hFF, 1'b0);
        releaseEn();

        runOp(8'd100, 8'hF6, 1'b1);
        releaseEn();

        // Abort on the fourth RUN step, with en still high alongside reset.
        A  = 8'd50;
        B  = 8'd60;
        en = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        lastOut = 16'h0000;
        checkOutput("abortOut", Output, 16'h0000);
        checkOutput("abortReady", {15'b0, ready}, 16'h0000);

        runOp(8'hFB, 8'd9, 1'b0);
        releaseEn();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
